// File: rtl/multi_dp_pkg.sv
// Shared encodings for the multi-cycle MIPS-subset datapath: opcodes, funct
// codes, control-FSM states and ALU operations.
package multi_dp_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_e;

  function automatic logic funct_known(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_op_e funct_to_alu(input logic [5:0] fn);
    case (fn)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      FN_OR:   return ALU_OR;
      FN_SLT:  return ALU_SLT;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/multi_dp_regfile.sv
// 32-entry register file: two async read ports, one debug read port, one
// synchronous write port. R0 is hardwired to zero and has no storage.
module multi_dp_regfile #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4:0]        raddr_a,
  input  logic [4:0]        raddr_b,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              wr_en,
  input  logic [4:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs_q [1:31];
  logic [DATA_W-1:0] regs_d [1:31];

  always_comb begin
    regs_d = regs_q;
    if (wr_en && (wr_addr != 5'd0)) regs_d[wr_addr] = wr_data;
  end

  // NOTE: this array is cleared by reset because software relies on all
  // registers reading zero after reset; a plain RAM would normally not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a   = (raddr_a   == 5'd0) ? '0 : regs_q[raddr_a];
  assign rdata_b   = (raddr_b   == 5'd0) ? '0 : regs_q[raddr_b];
  assign dbg_rdata = (dbg_raddr == 5'd0) ? '0 : regs_q[dbg_raddr];

endmodule

// File: rtl/multi_dp.sv
// Multi-cycle MIPS-subset CPU datapath: one shared ALU, one unified memory
// port with req/ready handshake, control FSM FETCH/DECODE/EXEC/MEM/WB/HALT.
module multi_dp
  import multi_dp_pkg::*;
#(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic              retire,
  input  logic [4:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, imm_q, imm_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d, mdr_q, mdr_d;
  logic              retire_q, retire_d;

  logic [DATA_W-1:0] rdata_a, rdata_b;
  logic              wr_en;
  logic [4:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              req;

  logic [5:0]        opcode, funct;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_res;
  logic              slt_bit;
  logic signed [DATA_W-1:0] br_off;
  logic [27:0]       j_low;
  logic [ADDR_W-1:0] jump_target;

  assign opcode = ir_q[31:26];
  assign funct  = ir_q[5:0];

  multi_dp_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a   (ir_q[25:21]),
    .raddr_b   (ir_q[20:16]),
    .dbg_raddr (dbg_raddr),
    .rdata_a   (rdata_a),
    .rdata_b   (rdata_b),
    .dbg_rdata (dbg_rdata),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  // Shared ALU: R-type uses B, every other user (addi, lw/sw address) uses imm.
  always_comb begin
    alu_op  = (opcode == OP_RTYPE) ? funct_to_alu(funct) : ALU_ADD;
    alu_b   = (opcode == OP_RTYPE) ? b_q : imm_q;
    slt_bit = $signed(a_q) < $signed(alu_b);
    case (alu_op)
      ALU_SUB: alu_res = a_q - alu_b;
      ALU_AND: alu_res = a_q & alu_b;
      ALU_OR:  alu_res = a_q | alu_b;
      ALU_SLT: alu_res = {{(DATA_W-1){1'b0}}, slt_bit};
      default: alu_res = a_q + alu_b;
    endcase
  end

  // Branch offset is sign-extended into the PC width; jump keeps PC's top bits
  // above bit 27 and, for narrow PCs, simply drops the upper target bits.
  assign br_off      = $signed({imm_q[DATA_W-3:0], 2'b00});
  assign j_low       = {ir_q[25:0], 2'b00};
  assign jump_target = (pc_q & ~ADDR_W'(28'hFFF_FFFF)) | ADDR_W'(j_low);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    imm_d     = imm_q;
    alu_out_d = alu_out_q;
    mdr_d     = mdr_q;
    retire_d  = 1'b0;
    req       = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = pc_q;
    wr_en     = 1'b0;
    wr_addr   = ir_q[20:16];
    wr_data   = alu_out_q;

    case (state_q)
      ST_FETCH: begin
        req = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_rdata[31:0];
          pc_d    = pc_q + ADDR_W'(4);
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_d   = rdata_a;
        b_d   = rdata_b;
        imm_d = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
        case (opcode)
          OP_RTYPE: begin
            if (funct_known(funct)) begin
              state_d = ST_EXEC;
            end else begin
              state_d  = ST_FETCH;
              retire_d = 1'b1;
            end
          end
          OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: state_d = ST_EXEC;
          OP_HALT: begin
            state_d  = ST_HALT;
            retire_d = 1'b1;
          end
          default: begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
        endcase
      end
      ST_EXEC: begin
        alu_out_d = alu_res;
        case (opcode)
          OP_RTYPE, OP_ADDI: state_d = ST_WB;
          OP_LW, OP_SW:      state_d = ST_MEM;
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + ADDR_W'(br_off);
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
          OP_J: begin
            pc_d     = jump_target;
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
          default: begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end
        endcase
      end
      ST_MEM: begin
        req      = 1'b1;
        mem_we   = (opcode == OP_SW);
        mem_addr = ADDR_W'(alu_out_q);
        if (mem_ready) begin
          if (opcode == OP_SW) begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
          end else begin
            mdr_d   = mem_rdata;
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        wr_en    = 1'b1;
        state_d  = ST_FETCH;
        retire_d = 1'b1;
        case (opcode)
          OP_RTYPE: wr_addr = ir_q[15:11];
          OP_LW:    wr_data = mdr_q;
          default:  ;
        endcase
      end
      ST_HALT: ;
      default: state_d = ST_FETCH;
    endcase
  end

  // Reset parks the FSM in FETCH, which would otherwise request; gating with
  // rst_n drops the request the moment reset asserts.
  assign mem_req   = req & rst_n;
  assign mem_wdata = b_q;
  assign pc_out    = pc_q;
  assign halted    = (state_q == ST_HALT);
  assign retire    = retire_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      imm_q     <= '0;
      alu_out_q <= '0;
      mdr_q     <= '0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      imm_q     <= imm_d;
      alu_out_q <= alu_out_d;
      mdr_q     <= mdr_d;
      retire_q  <= retire_d;
    end
  end

endmodule

// File: tb/tb_multi_dp.sv
// Bench for multi_dp: table of small programs run to HALT against a
// wait-state memory model, plus reset, jump-loop and mid-transfer reset cases.
module tb_multi_dp;

  localparam logic [31:0] RST_PC = 32'h100;
  localparam logic [31:0] HLT    = {6'h3F, 26'd0};
  localparam int          NV     = 13;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc_out;
  logic        halted, retire;
  logic [4:0]  dbg_raddr = '0;
  logic [31:0] dbg_rdata;

  multi_dp #(.DATA_W(32), .ADDR_W(32), .RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .halted    (halted),
    .retire    (retire),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction
  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction
  function automatic logic [31:0] addi(input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
    return enc_i(6'h08, rs, rt, imm);
  endfunction
  function automatic logic [31:0] jmp(input logic [25:0] tgt);
    return {6'h02, tgt};
  endfunction

  // Memory model: fixed wait states per transfer, write scoreboard, read log.
  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t         exp_wr[$];
  logic [31:0] rd_log[$];
  logic [31:0] mem [256];
  int          cur_waits = 0;
  int          wait_cnt = 0;
  logic        pending = 1'b0;
  logic [31:0] hold_addr, hold_wdata;
  logic        hold_we;

  always @(negedge clk) begin
    if (mem_req) begin
      if (pending) begin
        check("stable_addr", mem_addr, hold_addr);
        check("stable_we", {31'd0, mem_we}, {31'd0, hold_we});
        check("stable_wdata", mem_wdata, hold_wdata);
      end
      hold_addr  = mem_addr;
      hold_we    = mem_we;
      hold_wdata = mem_wdata;
      if (wait_cnt == cur_waits) begin
        mem_ready = 1'b1;
        wait_cnt  = 0;
        pending   = 1'b0;
        if (mem_we) begin
          mem[mem_addr[9:2]] = mem_wdata;
          if (exp_wr.size() == 0) begin
            check("unexpected_write_addr", mem_addr, 32'hFFFF_FFFF);
          end else begin
            wr_t e;
            e = exp_wr.pop_front();
            check("write_addr", mem_addr, e.addr);
            check("write_data", mem_wdata, e.data);
          end
        end else begin
          mem_rdata = mem[mem_addr[9:2]];
          rd_log.push_back(mem_addr);
        end
      end else begin
        mem_ready = 1'b0;
        wait_cnt++;
        pending   = 1'b1;
      end
    end else begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      pending   = 1'b0;
    end
  end

  task automatic load_prog(input logic [31:0] p [6]);
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[32] = 32'h7FFF_FFFF;
    for (int i = 0; i < 6; i++) mem[RST_PC[9:2] + 8'(i)] = p[i];
    rd_log.delete();
  endtask

  task automatic start(input int waits);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    cur_waits = waits;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    string       name;
    logic [31:0] prog [6];
    int          waits;
    logic [4:0]  rsel;
    logic [31:0] exp_val;
    int          exp_retire;
    int          exp_cycles;
    logic        has_wr;
    wr_t         wr;
  } vec_t;

  vec_t vecs [NV];

  task automatic set_vec(input int i, input string n, input int w, input logic [4:0] rs,
                         input logic [31:0] ev, input int er, input int ec);
    vecs[i].name       = n;
    vecs[i].waits      = w;
    vecs[i].rsel       = rs;
    vecs[i].exp_val    = ev;
    vecs[i].exp_retire = er;
    vecs[i].exp_cycles = ec;
    vecs[i].has_wr     = 1'b0;
    vecs[i].wr         = '{32'd0, 32'd0};
  endtask

  initial begin
    int cyc, ret, halt_cyc;
    logic done, found;
    logic [31:0] p [6];

    // Cycle counts number the first FETCH cycle after reset release as 1
    // and give the cycle in which halted is first high.
    set_vec(0, "addi_add", 0, 3, 32'd2, 4, 15);
    vecs[0].prog = '{addi(1, 0, 5), addi(2, 0, 16'hFFFD), enc_r(3, 1, 2, 6'h20), HLT, HLT, HLT};
    set_vec(1, "addi_add_w1", 1, 3, 32'd2, 4, 19);
    vecs[1].prog = vecs[0].prog;
    set_vec(2, "r0_write", 0, 0, 32'd0, 2, 7);
    vecs[2].prog = '{addi(0, 0, 7), HLT, HLT, HLT, HLT, HLT};
    set_vec(3, "slt_neg", 0, 3, 32'd1, 4, 15);
    vecs[3].prog = '{addi(1, 0, 16'hFFFF), addi(2, 0, 1), enc_r(3, 1, 2, 6'h2A), HLT, HLT, HLT};
    set_vec(4, "sub", 0, 3, 32'hFFFF_FFF9, 4, 15);
    vecs[4].prog = '{addi(1, 0, 3), addi(2, 0, 10), enc_r(3, 1, 2, 6'h22), HLT, HLT, HLT};
    set_vec(5, "and", 0, 3, 32'd8, 4, 15);
    vecs[5].prog = '{addi(1, 0, 12), addi(2, 0, 10), enc_r(3, 1, 2, 6'h24), HLT, HLT, HLT};
    set_vec(6, "or", 0, 3, 32'd14, 4, 15);
    vecs[6].prog = '{addi(1, 0, 12), addi(2, 0, 10), enc_r(3, 1, 2, 6'h25), HLT, HLT, HLT};
    set_vec(7, "unknown_ops", 0, 5, 32'd9, 4, 0);
    vecs[7].prog = '{addi(5, 0, 9), enc_i(6'h3E, 5, 5, 1), enc_r(5, 5, 5, 6'h21), HLT, HLT, HLT};
    set_vec(8, "add_wrap", 0, 3, 32'h8000_0000, 4, 16);
    vecs[8].prog = '{enc_i(6'h23, 0, 1, 16'h80), addi(2, 0, 1), enc_r(3, 1, 2, 6'h20), HLT, HLT, HLT};
    set_vec(9, "sw_lw_w2", 2, 4, 32'd5, 4, 28);
    vecs[9].prog = '{addi(1, 0, 5), enc_i(6'h2B, 0, 1, 8), enc_i(6'h23, 0, 4, 8), HLT, HLT, HLT};
    vecs[9].has_wr = 1'b1;
    vecs[9].wr     = '{32'd8, 32'd5};
    set_vec(10, "beq_taken", 0, 4, 32'd1, 4, 14);
    vecs[10].prog = '{addi(1, 0, 1), enc_i(6'h04, 1, 1, 2), addi(4, 0, 7), addi(4, 0, 8), addi(4, 4, 1), HLT};
    set_vec(11, "beq_not_taken", 0, 4, 32'd7, 4, 14);
    vecs[11].prog = '{addi(1, 0, 1), enc_i(6'h04, 1, 2, 1), addi(4, 0, 7), HLT, HLT, HLT};
    set_vec(12, "jump", 0, 4, 32'd2, 4, 14);
    vecs[12].prog = '{addi(1, 0, 1), jmp(26'h43), addi(4, 0, 5), addi(4, 4, 2), HLT, HLT};

    // Reset state and first fetch.
    load_prog(vecs[0].prog);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);
    check("rst_pc", pc_out, RST_PC);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, RST_PC);
    @(posedge clk);
    #1 check("decode_pc", pc_out, RST_PC + 32'd4);

    for (int v = 0; v < NV; v++) begin
      load_prog(vecs[v].prog);
      exp_wr.delete();
      if (vecs[v].has_wr) exp_wr.push_back(vecs[v].wr);
      start(vecs[v].waits);
      cyc = 0;
      ret = 0;
      done = 1'b0;
      while (!done && cyc < 400) begin
        @(negedge clk);
        cyc++;
        if (retire) ret++;
        if (halted) done = 1'b1;
      end
      check({vecs[v].name, "_halted"}, {31'd0, done}, 32'd1);
      halt_cyc = cyc;
      repeat (3) begin
        @(negedge clk);
        if (retire) ret++;
      end
      check({vecs[v].name, "_retires"}, ret, vecs[v].exp_retire);
      if (vecs[v].exp_cycles != 0) check({vecs[v].name, "_cycles"}, halt_cyc, vecs[v].exp_cycles);
      dbg_raddr = vecs[v].rsel;
      #1 check({vecs[v].name, "_reg"}, dbg_rdata, vecs[v].exp_val);
      check({vecs[v].name, "_writes_left"}, exp_wr.size(), 0);
    end

    // Jump back to 0x100 forms a loop: addi r1,r1,1 ; j 0x40.
    p = '{addi(1, 1, 1), jmp(26'h40), HLT, HLT, HLT, HLT};
    load_prog(p);
    start(0);
    cyc = 0;
    ret = 0;
    while (ret < 5 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (retire) ret++;
    end
    check("jloop_retires", ret, 5);
    dbg_raddr = 5'd1;
    #1 check("jloop_r1", dbg_rdata, 32'd3);
    check("jloop_fetches", {31'd0, rd_log.size() >= 3}, 32'd1);
    if (rd_log.size() >= 3) check("jloop_target", rd_log[2], RST_PC);

    // Reset asserted while an lw is stalled in MEM.
    p = '{addi(1, 0, 5), enc_i(6'h23, 0, 4, 8), HLT, HLT, HLT, HLT};
    load_prog(p);
    start(3);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 60) begin
      @(negedge clk);
      #1;
      cyc++;
      if (mem_req && !mem_we && mem_addr == 32'd8 && !mem_ready) found = 1'b1;
    end
    check("mid_rst_found_stall", {31'd0, found}, 32'd1);
    rst_n = 1'b0;
    #1 check("mid_rst_req_drop", {31'd0, mem_req}, 32'd0);
    dbg_raddr = 5'd1;
    #1 check("mid_rst_r1_clear", dbg_rdata, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("mid_rst_refetch_req", {31'd0, mem_req}, 32'd1);
    check("mid_rst_refetch_addr", mem_addr, RST_PC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
